sprite_fetch_sequencer: RTL and testbench

SPRITE_FETCH_SEQUENCER -- requirements
Module: sprite_fetch_sequencer

---
 rtl/sprite_fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_sprite_fetch_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch_sequencer
// Function : Issues up to 8 secondary-OAM pattern fetches per scanline and
//            writes returned pattern planes into the sprite shifter bank.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_fetch_sequencer #(
    parameter int FETCH_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] sprite_count,
    output logic [2:0] spr_idx,
    input  logic [7:0] spr_tile,
    input  logic [2:0] spr_yoff,
    input  logic       spr_vflip,
    output logic [7:0] pt_tile_num,
    output logic [2:0] pt_yoffset,
    input  logic [7:0] pt_line0,
    input  logic [7:0] pt_line1,
    output logic       wr_en,
    output logic [2:0] wr_idx,
    output logic [7:0] wr_line0,
    output logic [7:0] wr_line1,
    output logic       busy,
    output logic       done
);

    localparam int c_tail = FETCH_LAT - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [3:0]           r_count;
    logic [2:0]           r_idx;
    logic                 r_busy;
    logic                 r_done;
    logic [FETCH_LAT-1:0] r_valid;
    logic [2:0]           r_pidx [FETCH_LAT];

    logic [3:0]           w_n;
    logic                 w_issue;
    logic                 w_last_issue;
    logic                 w_kill;
    logic [FETCH_LAT-1:0] w_younger;
    logic                 w_last_write;

    assign w_n          = (sprite_count > 4'd8) ? 4'd8 : sprite_count;
    assign w_issue      = (r_state == ISSUE);
    assign w_last_issue = w_issue && ({1'b0, r_idx} == (r_count - 4'd1));
    assign w_kill       = abort && (r_state != IDLE);
    // Oldest stage is the last write only when no younger fetch is in flight.
    assign w_younger    = r_valid << 1;
    assign w_last_write = r_valid[c_tail] && (w_younger == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_idx   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_kill) begin
                r_state <= IDLE;
                r_idx   <= 3'd0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && !abort) begin
                            r_count <= w_n;
                            r_busy  <= 1'b1;
                            if (w_n == 4'd0) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        if (w_last_issue) begin
                            r_state <= DRAIN;
                            r_idx   <= 3'd0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                    DRAIN: begin
                        if (w_last_write) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Valid/index delay line matching the pattern-table read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < FETCH_LAT; i++) r_pidx[i] <= 3'd0;
        end else if (w_kill) begin
            r_valid <= '0;
            for (int i = 0; i < FETCH_LAT; i++) r_pidx[i] <= 3'd0;
        end else begin
            r_valid[0] <= w_issue;
            r_pidx[0]  <= w_issue ? r_idx : 3'd0;
            for (int i = 1; i < FETCH_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_pidx[i]  <= r_pidx[i-1];
            end
        end
    end

    assign spr_idx     = r_idx;
    assign pt_tile_num = w_issue ? spr_tile : 8'd0;
    assign pt_yoffset  = w_issue ? (spr_vflip ? (3'd7 - spr_yoff) : spr_yoff) : 3'd0;

    assign wr_en    = r_valid[c_tail];
    assign wr_idx   = r_valid[c_tail] ? r_pidx[c_tail] : 3'd0;
    assign wr_line0 = r_valid[c_tail] ? pt_line0 : 8'd0;
    assign wr_line1 = r_valid[c_tail] ? pt_line1 : 8'd0;

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_fetch_sequencer
// Function : Scoreboard bench for sprite_fetch_sequencer with a modelled
//            fixed-latency pattern table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch_sequencer;

    localparam int FL = 2;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [3:0] sprite_count;
    logic [2:0] spr_idx, spr_yoff, pt_yoffset, wr_idx;
    logic [7:0] spr_tile, pt_tile_num, pt_line0, pt_line1, wr_line0, wr_line1;
    logic       spr_vflip, wr_en, busy, done;

    logic [7:0] tiles [8];
    logic [2:0] yoffs [8];
    logic       flips [8];

    int cyc = 0;
    int t0  = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         rel;
        logic [2:0] idx;
        logic [7:0] l0;
        logic [7:0] l1;
    } wexp_t;

    wexp_t wq[$];
    int    dq[$];

    sprite_fetch_sequencer #(.FETCH_LAT(FL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sprite_count(sprite_count), .spr_idx(spr_idx), .spr_tile(spr_tile),
        .spr_yoff(spr_yoff), .spr_vflip(spr_vflip), .pt_tile_num(pt_tile_num),
        .pt_yoffset(pt_yoffset), .pt_line0(pt_line0), .pt_line1(pt_line1),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_line0(wr_line0), .wr_line1(wr_line1),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign spr_tile  = tiles[spr_idx];
    assign spr_yoff  = yoffs[spr_idx];
    assign spr_vflip = flips[spr_idx];

    // Pattern table: data is a fixed function of the address seen FL cycles earlier.
    function automatic logic [15:0] tbl(input logic [7:0] t, input logic [2:0] y);
        tbl = {t + 8'h40 + {5'd0, y}, ~t ^ {y, 5'd0}};
    endfunction

    logic [10:0] apipe [1:FL];
    always @(posedge clk) begin
        apipe[1] <= {pt_tile_num, pt_yoffset};
        for (int i = 2; i <= FL; i++) apipe[i] <= apipe[i-1];
    end
    assign {pt_line0, pt_line1} = tbl(apipe[FL][10:3], apipe[FL][2:0]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes / done pulses as the DUT presents them.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr", {wr_idx, wr_line0, wr_line1}, 64'hDEAD);
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("wr", {32'(cyc - t0), 5'd0, wr_idx, wr_line0, wr_line1},
                              {32'(e.rel), 5'd0, e.idx, e.l0, e.l1});
                end
            end else begin
                chk("wr_idle_zero", {wr_idx, wr_line0, wr_line1}, 64'd0);
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 64'(cyc - t0), 64'hDEAD);
                else chk("done_cycle", 64'(cyc - t0), 64'(dq.pop_front()));
            end
            if (!busy) chk("idle_addr_zero", {spr_idx, pt_tile_num, pt_yoffset}, 64'd0);
        end
    end

    task automatic expect_fetch(input int n, input bit with_done);
        for (int k = 0; k < n; k++) begin
            wexp_t e;
            logic [2:0] y;
            y = flips[k] ? (3'd7 - yoffs[k]) : yoffs[k];
            e.rel = 1 + k + FL;
            e.idx = 3'(k);
            {e.l0, e.l1} = tbl(tiles[k], y);
            wq.push_back(e);
        end
        if (with_done) dq.push_back((n == 0) ? 1 : n + FL + 1);
    endtask

    task automatic pulse_start(input logic [3:0] cnt);
        @(negedge clk);
        sprite_count = cnt;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        int guard = 0;
        while ((cyc - t0) < r && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic settle(input string name);
        repeat (FL + 12) @(negedge clk);
        chk({name, "_wq_empty"}, 64'(wq.size()), 64'd0);
        chk({name, "_dq_empty"}, 64'(dq.size()), 64'd0);
        chk({name, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sprite_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            tiles[i] = 8'h00; yoffs[i] = 3'd0; flips[i] = 1'b0;
        end
        #1;
        chk("reset_outputs", {busy, done, wr_en, wr_idx, wr_line0, wr_line1,
                              spr_idx, pt_tile_num, pt_yoffset}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic N=3 fetch; later sprite_count change must not matter.
        for (int i = 0; i < 3; i++) begin
            tiles[i] = 8'h10 + 8'(i); yoffs[i] = 3'd5; flips[i] = 1'b0;
        end
        expect_fetch(3, 1'b1);
        pulse_start(4'd3);
        sprite_count = 4'd7;
        chk("busy_rel1", {63'd0, busy}, 64'd1);
        chk("pt_rel1", {spr_idx, pt_tile_num, pt_yoffset}, {3'd0, 8'h10, 3'd5});
        wait_rel(2);
        chk("pt_rel2", {spr_idx, pt_tile_num, pt_yoffset}, {3'd1, 8'h11, 3'd5});
        wait_rel(3);
        chk("pt_rel3", {spr_idx, pt_tile_num, pt_yoffset}, {3'd2, 8'h12, 3'd5});
        wait_rel(4);
        chk("pt_rel4_zero", {spr_idx, pt_tile_num, pt_yoffset}, 64'd0);
        settle("n3");

        // Count above 8 clamps to 8.
        for (int i = 0; i < 8; i++) begin
            tiles[i] = 8'hA0 + 8'(i * 3); yoffs[i] = 3'(i); flips[i] = i[0];
        end
        expect_fetch(8, 1'b1);
        pulse_start(4'd12);
        settle("clamp");

        // Zero sprites: done one cycle after start, no fetch.
        expect_fetch(0, 1'b1);
        pulse_start(4'd0);
        chk("n0_busy_rel1", {62'd0, busy, done}, 64'd3);
        wait_rel(2);
        chk("n0_busy_rel2", {62'd0, busy, done}, 64'd0);
        settle("n0");

        // Vertical flip mirrors the row.
        tiles[0] = 8'h33; yoffs[0] = 3'd2; flips[0] = 1'b1;
        tiles[1] = 8'h34; yoffs[1] = 3'd0; flips[1] = 1'b1;
        expect_fetch(2, 1'b1);
        pulse_start(4'd2);
        chk("vflip_y2", {61'd0, pt_yoffset}, 64'd5);
        wait_rel(2);
        chk("vflip_y0", {61'd0, pt_yoffset}, 64'd7);
        settle("vflip");

        // Abort at cycle 3 of N=5, with an ignored second start while busy.
        for (int i = 0; i < 5; i++) begin
            tiles[i] = 8'h50 + 8'(i); yoffs[i] = 3'd1; flips[i] = 1'b0;
        end
        expect_fetch(1, 1'b0);
        pulse_start(4'd5);
        start = 1'b1; sprite_count = 4'd2;
        wait_rel(2);
        start = 1'b0;
        chk("restart_ignored_idx", {61'd0, spr_idx}, 64'd1);
        wait_rel(3);
        abort = 1'b1;
        wait_rel(4);
        abort = 1'b0;
        chk("abort_idle_rel4", {62'd0, busy, wr_en}, 64'd0);
        settle("abort");

        // Abort and start together in IDLE: start is ignored.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; sprite_count = 4'd4; t0 = cyc;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", {63'd0, busy}, 64'd0);
        settle("abort_start");

        // Reset mid-drain discards pending writes.
        for (int i = 0; i < 8; i++) begin
            tiles[i] = 8'hC0 + 8'(i); yoffs[i] = 3'(7 - i); flips[i] = 1'b0;
        end
        expect_fetch(6, 1'b0);
        pulse_start(4'd8);
        wait_rel(8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midreset_outputs", {busy, done, wr_en, wr_idx, wr_line0, wr_line1,
                                   spr_idx, pt_tile_num, pt_yoffset}, 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        settle("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
